// File: rtl/hazard_scoreboard_if.sv
// Decode-to-hazard-unit bundle: decode-stage instruction fields in, forwarding
// selects, stall/flush controls and the stall performance counter out.
interface hazard_scoreboard_if #(
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3,
    parameter int STALL_CW = 16
) ();
    logic                id_valid;
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic                id_rs1_used;
    logic                id_rs2_used;
    logic [REG_AW-1:0]   id_rd;
    logic                id_rd_we;
    logic [LAT_W-1:0]    id_lat;
    logic                branch_taken;
    logic                forward_a;
    logic                forward_b;
    logic                stall_if;
    logic                stall_id_exec;
    logic                flush_id_exec;
    logic                flush_if_id;
    logic [STALL_CW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_lat, branch_taken,
        input  forward_a, forward_b, stall_if, stall_id_exec,
               flush_id_exec, flush_if_id, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_lat, branch_taken,
        output forward_a, forward_b, stall_if, stall_id_exec,
               flush_id_exec, flush_if_id, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for variable-latency writes: produces
// forwarding selects, RAW/WAW stalls and branch flushes at the decode boundary.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = 3,
    parameter int STALL_CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << REG_AW;

    // Entries at or above NUM_REGS (and entry 0) are never loaded, so they read as 0.
    logic [LAT_W-1:0]    cnt_q [DEPTH];
    logic [LAT_W-1:0]    cnt_d [DEPTH];
    logic [STALL_CW-1:0] stall_cnt_q;
    logic [STALL_CW-1:0] stall_cnt_d;

    logic [LAT_W-1:0] lat_eff;
    logic [LAT_W-1:0] cnt_rs1;
    logic [LAT_W-1:0] cnt_rs2;
    logic [LAT_W-1:0] cnt_rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             fwd_a;
    logic             fwd_b;
    logic             raw_stall;
    logic             waw_stall;
    logic             stall;
    logic             issue;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        lat_eff = bus.id_lat;
        if (bus.id_lat == '0) begin
            lat_eff = LAT_W'(1);
        end else if (bus.id_lat > LAT_W'(MAX_LAT)) begin
            lat_eff = LAT_W'(MAX_LAT);
        end

        cnt_rs1 = cnt_q[bus.id_rs1];
        cnt_rs2 = cnt_q[bus.id_rs2];
        cnt_rd  = cnt_q[bus.id_rd];

        use_rs1 = bus.id_valid & bus.id_rs1_used & (bus.id_rs1 != '0);
        use_rs2 = bus.id_valid & bus.id_rs2_used & (bus.id_rs2 != '0);

        // A count of 1 means the producer's result is on the forward bus right now.
        fwd_a     = use_rs1 & (cnt_rs1 == LAT_W'(1));
        fwd_b     = use_rs2 & (cnt_rs2 == LAT_W'(1));
        raw_stall = (use_rs1 & (cnt_rs1 >= LAT_W'(2))) |
                    (use_rs2 & (cnt_rs2 >= LAT_W'(2)));
        waw_stall = bus.id_valid & bus.id_rd_we & (bus.id_rd != '0) & (cnt_rd > lat_eff);

        stall = (raw_stall | waw_stall) & ~bus.branch_taken;
        issue = bus.id_valid & ~stall & ~bus.branch_taken;

        cnt_d = '{default: '0};
        for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
            if (issue & bus.id_rd_we & (bus.id_rd == REG_AW'(r))) begin
                cnt_d[r] = lat_eff;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the counter array must be cleared on reset; a pending write must not survive it.
            cnt_q       <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // All outputs are held at 0 while reset is asserted.
    assign bus.forward_a     = fwd_a & ~rst;
    assign bus.forward_b     = fwd_b & ~rst;
    assign bus.stall_if      = stall & ~rst;
    assign bus.stall_id_exec = stall & ~rst;
    assign bus.flush_id_exec = (stall | bus.branch_taken) & ~rst;
    assign bus.flush_if_id   = bus.branch_taken & ~rst;
    assign bus.stall_cnt     = rst ? '0 : stall_cnt_q;

endmodule
